// File: rtl/pipeline_wb_trace.sv
// Write-back trace buffer: time-stamps accepted WB register writes into a FWFT FIFO.
// Optional trigger/freeze capture enabled by defining TRACE_TRIGGER_EN.
module pipeline_wb_trace #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned FILTER_R0  = 1,
    parameter int unsigned POST_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wb_valid,
    input  logic [REG_AW-1:0]          wb_reg,
    input  logic [DATA_W-1:0]          wb_data,
`ifdef TRACE_TRIGGER_EN
    input  logic                       arm,
    input  logic [REG_AW-1:0]          trig_reg,
    input  logic [DATA_W-1:0]          trig_data,
    input  logic [DATA_W-1:0]          trig_mask,
    output logic                       frozen,
`endif
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [REG_AW-1:0]          rd_reg,
    output logic [DATA_W-1:0]          rd_data,
    output logic [CNT_W-1:0]           rd_stamp,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [REG_AW-1:0] reg_mem_q   [DEPTH];
    logic [DATA_W-1:0] data_mem_q  [DEPTH];
    logic [CNT_W-1:0]  stamp_mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W-1:0] stamp_q, stamp_d;

    logic cap_en;
    logic filtered;
    logic accept;
    logic full;
    logic pop;
    logic push;
    logic lost;

`ifdef TRACE_TRIGGER_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_POST,
        ST_FROZEN
    } trig_state_e;

    localparam int unsigned PW        = $clog2(POST_DEPTH + 1) + 1;
    localparam logic [PW-1:0] POST_LD = PW'(POST_DEPTH);

    trig_state_e   state_q, state_d;
    logic [PW-1:0] post_cnt_q, post_cnt_d;
    logic          hit;

    assign cap_en = (state_q != ST_FROZEN);
    assign frozen = (state_q == ST_FROZEN);
    assign hit    = accept && (wb_reg == trig_reg)
                    && ((wb_data & trig_mask) == (trig_data & trig_mask));

    always_comb begin
        state_d    = state_q;
        post_cnt_d = post_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arm) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (hit) begin
                    post_cnt_d = POST_LD;
                    state_d    = (POST_DEPTH == 0) ? ST_FROZEN : ST_POST;
                end
            end
            ST_POST: begin
                if (push) begin
                    post_cnt_d = post_cnt_q - 1'b1;
                    if (post_cnt_q == PW'(1)) state_d = ST_FROZEN;
                end
            end
            default: ;
        endcase
        if (clear) begin
            state_d    = ST_IDLE;
            post_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            post_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            post_cnt_q <= post_cnt_d;
        end
    end
`else
    assign cap_en = 1'b1;
`endif

    assign filtered = (FILTER_R0 != 0) && (wb_reg == '0);
    assign accept   = wb_valid && !filtered && cap_en;
    assign full     = (count_q == FULL_CNT);
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && rd_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still takes the write.
    assign push     = accept && (!full || pop) && !clear;
    assign lost     = accept && full && !pop && !clear;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        stamp_d    = stamp_q + 1'b1;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (lost) begin
                overflow_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            stamp_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            stamp_q    <= stamp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem_q[wr_ptr_q]   <= wb_reg;
            data_mem_q[wr_ptr_q]  <= wb_data;
            stamp_mem_q[wr_ptr_q] <= stamp_q;
        end
    end

    assign rd_reg   = rd_valid ? reg_mem_q[rd_ptr_q]   : '0;
    assign rd_data  = rd_valid ? data_mem_q[rd_ptr_q]  : '0;
    assign rd_stamp = rd_valid ? stamp_mem_q[rd_ptr_q] : '0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_pipeline_wb_trace.sv
// Directed bench for pipeline_wb_trace with a queue scoreboard of expected trace entries.
// The trigger section runs only when TRACE_TRIGGER_EN is defined.
module tb_pipeline_wb_trace;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        rd_ready;
    logic        rd_valid;
    logic [4:0]  rd_reg;
    logic [31:0] rd_data;
    logic [15:0] rd_stamp;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    logic        nf_rd_valid;
    logic [4:0]  nf_rd_reg;
    logic [31:0] nf_rd_data;
    logic [15:0] nf_rd_stamp;
    logic [4:0]  nf_count;
    logic        nf_overflow;
    logic [15:0] nf_drop_cnt;

    logic        arm;
    logic [4:0]  trig_reg;
    logic [31:0] trig_data;
    logic [31:0] trig_mask;
    logic        frozen;
    logic        nf_frozen;

    always #5 clk = ~clk;

    pipeline_wb_trace #(.DATA_W(32), .REG_AW(5), .DEPTH(16), .CNT_W(16),
                        .FILTER_R0(1), .POST_DEPTH(2)) dut (
        .clk(clk), .reset(rst), .clear(clear),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
`ifdef TRACE_TRIGGER_EN
        .arm(arm), .trig_reg(trig_reg), .trig_data(trig_data), .trig_mask(trig_mask),
        .frozen(frozen),
`endif
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_reg(rd_reg), .rd_data(rd_data),
        .rd_stamp(rd_stamp), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    pipeline_wb_trace #(.DATA_W(32), .REG_AW(5), .DEPTH(16), .CNT_W(16),
                        .FILTER_R0(0), .POST_DEPTH(2)) dut_nf (
        .clk(clk), .reset(rst), .clear(clear),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
`ifdef TRACE_TRIGGER_EN
        .arm(1'b0), .trig_reg(5'd0), .trig_data(32'd0), .trig_mask(32'd0),
        .frozen(nf_frozen),
`endif
        .rd_valid(nf_rd_valid), .rd_ready(rd_ready), .rd_reg(nf_rd_reg), .rd_data(nf_rd_data),
        .rd_stamp(nf_rd_stamp), .count(nf_count), .overflow(nf_overflow), .drop_cnt(nf_drop_cnt)
    );

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
        logic [15:0] s;
    } ent_t;

    ent_t        mq[$];
    int          checks = 0;
    int          errors = 0;
    logic        m_ovf;
    logic [15:0] m_drop;
    logic [15:0] m_stamp;
    int          tst;
    int          post_left;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from current inputs, compare popped head, advance, then check state.
    task automatic tick();
        bit   pop_m, acc, pushed, hit;
        ent_t e;
        pop_m  = (mq.size() != 0) && rd_ready;
        acc    = wb_valid && (wb_reg != 5'd0) && (tst != 3);
        hit    = acc && (wb_reg == trig_reg) && ((wb_data & trig_mask) == (trig_data & trig_mask));
        pushed = 1'b0;
        if (pop_m) begin
            chk("pop_reg",   {59'd0, rd_reg},   {59'd0, mq[0].r});
            chk("pop_data",  {32'd0, rd_data},  {32'd0, mq[0].d});
            chk("pop_stamp", {48'd0, rd_stamp}, {48'd0, mq[0].s});
        end
        if (clear) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = '0;
            tst    = 0;
        end else begin
            if (pop_m) e = mq.pop_front();
            if (acc) begin
                if (mq.size() < 16) begin
                    mq.push_back('{r: wb_reg, d: wb_data, s: m_stamp});
                    pushed = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop++;
                end
            end
`ifdef TRACE_TRIGGER_EN
            case (tst)
                0: if (arm) tst = 1;
                1: if (hit) begin post_left = 2; tst = 2; end
                2: if (pushed) begin post_left--; if (post_left == 0) tst = 3; end
                default: ;
            endcase
`endif
        end
        m_stamp++;
        @(posedge clk);
        #1;
        chk("count",    {59'd0, count},    64'(mq.size()));
        chk("rd_valid", {63'd0, rd_valid}, {63'd0, mq.size() != 0});
        chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
        chk("drop_cnt", {48'd0, drop_cnt}, {48'd0, m_drop});
        if (mq.size() != 0) chk("head_reg", {59'd0, rd_reg}, {59'd0, mq[0].r});
        else                chk("empty_reg", {59'd0, rd_reg}, 64'd0);
`ifdef TRACE_TRIGGER_EN
        chk("frozen", {63'd0, frozen}, {63'd0, tst == 3});
`endif
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_reg   = r;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        rd_ready = 1'b0; arm = 1'b0; trig_reg = 5'd31; trig_data = '0; trig_mask = '0;
        m_ovf = 1'b0; m_drop = '0; m_stamp = '0; tst = 0; post_left = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",    {59'd0, count},    64'd0);
        chk("rst_valid",    {63'd0, rd_valid}, 64'd0);
        chk("rst_reg",      {59'd0, rd_reg},   64'd0);
        chk("rst_data",     {32'd0, rd_data},  64'd0);
        chk("rst_stamp",    {48'd0, rd_stamp}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_drop",     {48'd0, drop_cnt}, 64'd0);
        rst = 1'b0;

        // Three idle cycles so the writes land on stamps 3,4,5.
        repeat (3) tick();
        wr(5'd8, 32'd5);
        wr(5'd9, 32'd6);
        wr(5'd10, 32'd7);
        chk("t1_count", {59'd0, count},    64'd3);
        chk("t1_reg",   {59'd0, rd_reg},   64'd8);
        chk("t1_data",  {32'd0, rd_data},  64'd5);
        chk("t1_stamp", {48'd0, rd_stamp}, 64'd3);

        rd_ready = 1'b1;
        repeat (3) tick();
        rd_ready = 1'b0;
        chk("t2_valid", {63'd0, rd_valid}, 64'd0);
        chk("t2_count", {59'd0, count},    64'd0);

        wr(5'd0, 32'hFF);
        chk("t3_count",    {59'd0, count},       64'd0);
        chk("t3_drop",     {48'd0, drop_cnt},    64'd0);
        chk("t3_nf_count", {59'd0, nf_count},    64'd1);
        chk("t3_nf_valid", {63'd0, nf_rd_valid}, 64'd1);
        chk("t3_nf_reg",   {59'd0, nf_rd_reg},   64'd0);
        chk("t3_nf_data",  {32'd0, nf_rd_data},  64'hFF);
        chk("t3_nf_stamp", {48'd0, nf_rd_stamp}, 64'(m_stamp - 16'd1));
        chk("t3_nf_ovf",   {63'd0, nf_overflow}, 64'd0);
        chk("t3_nf_drop",  {48'd0, nf_drop_cnt}, 64'd0);
`ifdef TRACE_TRIGGER_EN
        chk("t3_nf_frozen", {63'd0, nf_frozen}, 64'd0);
`endif
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t3_nf_clr", {59'd0, nf_count}, 64'd0);

        for (int i = 1; i <= 20; i++) wr(5'(i), $urandom);
        chk("t4_count", {59'd0, count},    64'd16);
        chk("t4_ovf",   {63'd0, overflow}, 64'd1);
        chk("t4_drop",  {48'd0, drop_cnt}, 64'd4);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t4_clr_count", {59'd0, count},    64'd0);
        chk("t4_clr_ovf",   {63'd0, overflow}, 64'd0);
        chk("t4_clr_drop",  {48'd0, drop_cnt}, 64'd0);

        // A write in the clear cycle is neither stored nor counted.
        wr(5'd3, 32'h1234);
        clear = 1'b1; wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h55;
        tick();
        clear = 1'b0; wb_valid = 1'b0;
        chk("clr_wr_count", {59'd0, count}, 64'd0);

        for (int i = 0; i < 16; i++) wr(5'(i + 1), 32'h100 + 32'(i));
        rd_ready = 1'b1;
        wr(5'd21, 32'hABCD);
        rd_ready = 1'b0;
        chk("t5_count", {59'd0, count},    64'd16);
        chk("t5_drop",  {48'd0, drop_cnt}, 64'd0);
        chk("t5_head",  {59'd0, rd_reg},   64'd2);
        rd_ready = 1'b1;
        repeat (16) tick();
        rd_ready = 1'b0;
        chk("t5_empty", {63'd0, rd_valid}, 64'd0);

`ifdef TRACE_TRIGGER_EN
        clear = 1'b1; tick(); clear = 1'b0;
        trig_reg = 5'd4; trig_data = 32'h10; trig_mask = 32'hFFFF_FFFF;
        wr(5'd4, 32'h10);
        arm = 1'b1; tick(); arm = 1'b0;
        wr(5'd4, 32'h11);
        wr(5'd4, 32'h10);
        wr(5'd5, 32'h1);
        wr(5'd6, 32'h2);
        wr(5'd7, 32'h3);
        wr(5'd4, 32'h10);
        chk("t6_count",  {59'd0, count},    64'd5);
        chk("t6_frozen", {63'd0, frozen},   64'd1);
        chk("t6_drop",   {48'd0, drop_cnt}, 64'd0);
        rd_ready = 1'b1;
        repeat (5) tick();
        rd_ready = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t6_unfrozen", {63'd0, frozen}, 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
